// File: rtl/vdp_vram_write_queue_if.sv
// Host write port and VRAM arbiter write-slot signals of the VRAM write queue.
// master: CPU/arbiter side that drives requests and strobes; slave: the queue.
// Pure wiring, no state; clk and reset_n stay outside the bundle.
interface vdp_vram_write_queue_if;
    logic        host_address_we;
    logic [14:0] host_address;
    logic [7:0]  host_increment;
    logic        host_data_we;
    logic [15:0] host_data;
    logic        host_ready;
    logic        host_busy;
    logic        host_overflow;
    logic        vram_written;
    logic [13:0] vram_write_address_16b;
    logic [15:0] vram_write_data_16b;
    logic [1:0]  vram_port_write_en_mask;

    modport master (
        output host_address_we, host_address, host_increment,
        output host_data_we, host_data, vram_written,
        input  host_ready, host_busy, host_overflow,
        input  vram_write_address_16b, vram_write_data_16b, vram_port_write_en_mask
    );

    modport slave (
        input  host_address_we, host_address, host_increment,
        input  host_data_we, host_data, vram_written,
        output host_ready, host_busy, host_overflow,
        output vram_write_address_16b, vram_write_data_16b, vram_port_write_en_mask
    );
endinterface

// File: rtl/vdp_vram_write_queue.sv
// Buffers CPU VRAM writes in a DEPTH-entry FIFO and presents the head to the VRAM arbiter write slot.
// Latency: push at edge N is at the head from cycle N+1 (empty FIFO); popped on the first vram_written at/after that.
// Backpressure: host_ready low when full; pushes while full are dropped and set sticky host_overflow.
// Optional feature macro: VDP_VRAM_WRITE_AUTOINC_EN (pointer advances by host_increment per accepted push).
module vdp_vram_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    vdp_vram_write_queue_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [AW:0]   count;
    logic [14:0]   pointer;
    logic          overflow;

    logic   full;
    logic   empty;
    logic   push_ok;
    logic   pop_ok;
    entry_t head;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // Acceptance is decided from pre-edge count, so a same-cycle pop never rescues a push into a full queue.
    assign push_ok = bus.host_data_we && !full;
    assign pop_ok  = bus.vram_written && !empty;
    assign head    = mem[rd_idx];

    // Head presentation and host status, all derived from registered state.
    always_comb begin
        bus.host_ready              = !full;
        bus.host_busy               = !empty;
        bus.host_overflow           = overflow;
        bus.vram_write_address_16b  = '0;
        bus.vram_write_data_16b     = '0;
        bus.vram_port_write_en_mask = 2'b00;
        if (!empty) begin
            bus.vram_write_address_16b  = head.addr[14:1];
            bus.vram_write_data_16b     = head.data;
            bus.vram_port_write_en_mask = head.addr[0] ? 2'b10 : 2'b01;
        end
    end

    // FIFO storage and indices; push stores the pre-edge pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_idx] <= '{addr: pointer, data: bus.host_data};
                wr_idx      <= wr_idx + 1'b1;
            end
            if (pop_ok) begin
                rd_idx <= rd_idx + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: a dropped push sets it, an address load clears it; a drop in the same cycle wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (bus.host_data_we && full) begin
            overflow <= 1'b1;
        end else if (bus.host_address_we) begin
            overflow <= 1'b0;
        end
    end

`ifdef VDP_VRAM_WRITE_AUTOINC_EN
    // Address pointer: an explicit load beats the post-push increment; dropped pushes do not advance it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pointer <= '0;
        end else if (bus.host_address_we) begin
            pointer <= bus.host_address;
        end else if (push_ok) begin
            pointer <= pointer + {7'b0, bus.host_increment};
        end
    end
`else
    logic unused_increment;
    assign unused_increment = &{1'b0, bus.host_increment};

    // Address pointer: changes only on an explicit load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pointer <= '0;
        end else if (bus.host_address_we) begin
            pointer <= bus.host_address;
        end
    end
`endif

endmodule
